// File: rtl/dmem_port_arbiter_if.sv
// Requester-side data-memory access bus: request fields plus grant and response.
// Latency: none (wires only). Backpressure: the requester holds req until gnt is seen.
// Modports: master is the requester, slave is the arbiter.
interface dmem_port_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  read_status;
  logic [1:0]  write_status;
  logic        load_unsigned;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, wdata, read_status, write_status, load_unsigned,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, wdata, read_status, write_status, load_unsigned,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Core/loader arbiter for the single DMEM port, range-checked; DMEM_ARB_PERF_EN adds perf counters.
// Latency: grant and mem_* same cycle, response one cycle after issue, one access per cycle.
// Backpressure: the core is stalled while the loader owns the port; bounded bursts keep both sides live.
module dmem_port_arbiter #(
  parameter logic [31:0] DMEM_BASE     = 32'h0010_0000,
  parameter int unsigned DMEM_SIZE     = 32768,
  parameter int unsigned MAX_LDR_BURST = 4,
  parameter int unsigned MAX_CORE_RUN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_port_arbiter_if.slave    core,
  dmem_port_arbiter_if.slave    ldr,
  output logic                  core_stall,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [1:0]            mem_read_status,
  output logic [1:0]            mem_write_status,
  output logic                  mem_load_unsigned,
  input  logic [31:0]           mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           core_stall_cycles,
  output logic [31:0]           ldr_grant_count
`endif
);

  typedef enum logic [1:0] {IDLE, CORE, LDR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LDR} owner_t;

  // 33-bit bounds so an address near 32'hFFFF_FFFF cannot wrap into range
  localparam logic [32:0] ADDR_LO  = {1'b0, DMEM_BASE};
  localparam logic [32:0] ADDR_HI  = ADDR_LO + 33'(DMEM_SIZE);
  localparam logic [3:0]  CORE_LIM = 4'(MAX_CORE_RUN);
  localparam logic [3:0]  LDR_LIM  = 4'(MAX_LDR_BURST);

  state_t      state, state_n;
  logic [3:0]  run_cnt, run_cnt_n;
  logic        core_gnt, ldr_gnt;
  logic        oor;
  owner_t      resp_owner;
  logic        resp_err;
  logic        resp_rd;
  logic [31:0] sel_addr;
  logic [1:0]  sel_rs, sel_ws;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_n;
      run_cnt <= run_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    run_cnt_n = '0;
    core_gnt  = 1'b0;
    ldr_gnt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (core.req) begin
          core_gnt = 1'b1;
          state_n  = CORE;
        end else if (ldr.req) begin
          ldr_gnt = 1'b1;
          state_n = LDR;
        end
      end
      CORE: begin
        if (core.req && !(ldr.req && run_cnt == CORE_LIM)) begin
          core_gnt = 1'b1;
        end else if (ldr.req) begin
          ldr_gnt = 1'b1;
          state_n = LDR;
        end else begin
          state_n = IDLE;
        end
      end
      LDR: begin
        if (ldr.req && !(core.req && run_cnt == LDR_LIM)) begin
          ldr_gnt = 1'b1;
        end else if (core.req) begin
          core_gnt = 1'b1;
          state_n  = CORE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (reset) begin
      core_gnt = 1'b0;
      ldr_gnt  = 1'b0;
    end
    // The run counts grants made while the other side waits; a switching grant is the first of a run
    if (core_gnt && ldr.req) begin
      if (state != CORE)              run_cnt_n = 4'd1;
      else if (run_cnt >= CORE_LIM)   run_cnt_n = CORE_LIM;
      else                            run_cnt_n = run_cnt + 4'd1;
    end else if (ldr_gnt && core.req) begin
      if (state != LDR)               run_cnt_n = 4'd1;
      else if (run_cnt >= LDR_LIM)    run_cnt_n = LDR_LIM;
      else                            run_cnt_n = run_cnt + 4'd1;
    end
  end

  always_comb begin
    sel_addr          = '0;
    sel_rs            = '0;
    sel_ws            = '0;
    mem_wdata         = '0;
    mem_load_unsigned = 1'b0;
    if (core_gnt) begin
      sel_addr          = core.addr;
      sel_rs            = core.read_status;
      sel_ws            = core.write_status;
      mem_wdata         = core.wdata;
      mem_load_unsigned = core.load_unsigned;
    end else if (ldr_gnt) begin
      sel_addr          = ldr.addr;
      sel_rs            = ldr.read_status;
      sel_ws            = ldr.write_status;
      mem_wdata         = ldr.wdata;
      mem_load_unsigned = ldr.load_unsigned;
    end
    oor = (core_gnt || ldr_gnt) &&
          (({1'b0, sel_addr} < ADDR_LO) || ({1'b0, sel_addr} >= ADDR_HI));
    mem_addr         = sel_addr;
    mem_read_status  = oor ? 2'd0 : sel_rs;
    mem_write_status = oor ? 2'd0 : sel_ws;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
      resp_err   <= 1'b0;
      resp_rd    <= 1'b0;
    end else begin
      resp_owner <= core_gnt ? OWN_CORE : (ldr_gnt ? OWN_LDR : OWN_NONE);
      resp_err   <= oor;
      resp_rd    <= (mem_read_status != 2'd0);
    end
  end

  assign core.gnt    = core_gnt;
  assign ldr.gnt     = ldr_gnt;
  assign core_stall  = core.req && !core_gnt && !reset;

  assign core.rvalid = (resp_owner == OWN_CORE);
  assign core.err    = core.rvalid && resp_err;
  assign core.rdata  = (core.rvalid && resp_rd && !resp_err) ? mem_rdata : 32'd0;
  assign ldr.rvalid  = (resp_owner == OWN_LDR);
  assign ldr.err     = ldr.rvalid && resp_err;
  assign ldr.rdata   = (ldr.rvalid && resp_rd && !resp_err) ? mem_rdata : 32'd0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_stall_cycles <= '0;
      ldr_grant_count   <= '0;
    end else begin
      if (core_stall) core_stall_cycles <= core_stall_cycles + 32'd1;
      if (ldr_gnt)    ldr_grant_count   <= ldr_grant_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-wide DMEM model on the mem_* side.
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        core_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_read_status, mem_write_status;
  logic        mem_load_unsigned;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [16];

  dmem_port_arbiter_if core_if ();
  dmem_port_arbiter_if ldr_if ();

  dmem_port_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .core              (core_if),
    .ldr               (ldr_if),
    .core_stall        (core_stall),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_read_status   (mem_read_status),
    .mem_write_status  (mem_write_status),
    .mem_load_unsigned (mem_load_unsigned),
    .mem_rdata         (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0000_A5A5;
    mem[1]  = 32'hDEAD_BEEF;
    mem[15] = 32'h1234_5678;
  end

  // DMEM model: read data registered at the issue edge, word store on any nonzero store code
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[5:2]];
    if (mem_write_status != 2'd0) mem[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic core_drive(input logic req, input logic [31:0] addr, input logic [1:0] rs,
                            input logic [1:0] ws, input logic [31:0] wd);
    core_if.req = req; core_if.addr = addr; core_if.read_status = rs;
    core_if.write_status = ws; core_if.wdata = wd; core_if.load_unsigned = 1'b0;
  endtask

  task automatic ldr_drive(input logic req, input logic [31:0] addr, input logic [1:0] rs,
                           input logic [1:0] ws, input logic [31:0] wd);
    ldr_if.req = req; ldr_if.addr = addr; ldr_if.read_status = rs;
    ldr_if.write_status = ws; ldr_if.wdata = wd; ldr_if.load_unsigned = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_arb;
    reset = 1'b1;
    core_drive(0, 0, 0, 0, 0);
    ldr_drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_core_gnt", 32'(core_if.gnt), 32'd0);
    check("rst_rvalid", {30'd0, core_if.rvalid, ldr_if.rvalid}, 32'd0);
    check("rst_rdata", core_if.rdata | ldr_if.rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    tick;
    reset = 1'b0;

    // core word load
    core_drive(1, 32'h0010_0004, 2'd3, 2'd0, 32'd0);
    @(negedge clk);
    check("t1_gnt", {30'd0, core_if.gnt, ldr_if.gnt}, 32'd2);
    check("t1_mem_addr", mem_addr, 32'h0010_0004);
    check("t1_mem_rs", 32'(mem_read_status), 32'd3);
    tick;
    core_drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t1_rvalid", {30'd0, core_if.rvalid, core_if.err}, 32'd2);
    check("t1_rdata", core_if.rdata, 32'hDEAD_BEEF);
    check("t1_ldr_quiet", {29'd0, ldr_if.rvalid, ldr_if.err, ldr_if.gnt}, 32'd0);
    tick;

    // simultaneous requests: 8 core grants, 4 loader grants, then core again
    core_drive(1, 32'h0010_0000, 2'd0, 2'd0, 32'd0);
    ldr_drive(1, 32'h0010_0000, 2'd0, 2'd0, 32'd0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      exp_arb = (i < 8 || i >= 12) ? 3'b100 : 3'b011;
      check($sformatf("t2_arb_%0d", i), {29'd0, core_if.gnt, ldr_if.gnt, core_stall}, 32'(exp_arb));
      tick;
    end
    core_drive(0, 0, 0, 0, 0);
    ldr_drive(0, 0, 0, 0, 0);
    tick;

    // loader stores, core arrives during the 2nd and waits for the 3rd to finish
    ldr_drive(1, 32'h0010_0010, 2'd0, 2'd3, 32'h11);
    @(negedge clk);
    check("t3_c0", {29'd0, ldr_if.gnt, core_stall, core_if.gnt}, 32'd4);
    check("t3_c0_ws", 32'(mem_write_status), 32'd3);
    check("t3_c0_wdata", mem_wdata, 32'h11);
    tick;
    ldr_drive(1, 32'h0010_0014, 2'd0, 2'd3, 32'h22);
    core_drive(1, 32'h0010_0014, 2'd3, 2'd0, 32'd0);
    @(negedge clk);
    check("t3_c1", {29'd0, ldr_if.gnt, core_stall, core_if.gnt}, 32'd6);
    check("t3_c1_resp", {30'd0, ldr_if.rvalid, ldr_if.err}, 32'd2);
    check("t3_c1_rdata", ldr_if.rdata, 32'd0);
    tick;
    ldr_drive(1, 32'h0010_0018, 2'd0, 2'd3, 32'h33);
    @(negedge clk);
    check("t3_c2", {29'd0, ldr_if.gnt, core_stall, core_if.gnt}, 32'd6);
    tick;
    ldr_drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_c3", {29'd0, ldr_if.gnt, core_stall, core_if.gnt}, 32'd1);
    check("t3_c3_addr", mem_addr, 32'h0010_0014);
    tick;
    core_drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_load_rvalid", 32'(core_if.rvalid), 32'd1);
    check("t3_load_rdata", core_if.rdata, 32'h22);
    tick;

    // loader store one past the end
    ldr_drive(1, 32'h0010_8000, 2'd0, 2'd3, 32'h0000_FFFF);
    @(negedge clk);
    check("t4_gnt", 32'(ldr_if.gnt), 32'd1);
    check("t4_ws_forced", 32'(mem_write_status), 32'd0);
    tick;
    ldr_drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_resp", {30'd0, ldr_if.rvalid, ldr_if.err}, 32'd3);
    check("t4_rdata", ldr_if.rdata, 32'd0);
    check("t4_mem_kept", mem[0], 32'h0000_A5A5);
    tick;

    // core loads at the top of the address space, last valid word, just below base
    core_drive(1, 32'hFFFF_FFFC, 2'd3, 2'd0, 32'd0);
    @(negedge clk);
    check("t5_gnt", 32'(core_if.gnt), 32'd1);
    check("t5_rs_forced", 32'(mem_read_status), 32'd0);
    tick;
    core_drive(1, 32'h0010_7FFC, 2'd3, 2'd0, 32'd0);
    @(negedge clk);
    check("t5_wrap_resp", {30'd0, core_if.rvalid, core_if.err}, 32'd3);
    check("t5_wrap_rdata", core_if.rdata, 32'd0);
    tick;
    core_drive(1, 32'h000F_FFFC, 2'd3, 2'd0, 32'd0);
    @(negedge clk);
    check("t5_last_resp", {30'd0, core_if.rvalid, core_if.err}, 32'd2);
    check("t5_last_rdata", core_if.rdata, 32'h1234_5678);
    tick;
    core_drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t5_below_resp", {30'd0, core_if.rvalid, core_if.err}, 32'd3);
    tick;

    // reset right after a core grant
    core_drive(1, 32'h0010_0004, 2'd3, 2'd0, 32'd0);
    @(negedge clk);
    check("t6_gnt", 32'(core_if.gnt), 32'd1);
    tick;
    reset = 1'b1;
    #1;
    check("t6_async_ctl", {28'd0, core_if.rvalid, core_if.err, core_if.gnt, core_stall}, 32'd0);
    check("t6_async_rdata", core_if.rdata, 32'd0);
    check("t6_async_mem", mem_addr, 32'd0);
    core_drive(0, 0, 0, 0, 0);
    tick;
    tick;
    reset = 1'b0;
    @(negedge clk);
    check("t6_no_rvalid", {30'd0, core_if.rvalid, ldr_if.rvalid}, 32'd0);
    tick;
    core_drive(1, 32'h0010_0004, 2'd3, 2'd0, 32'd0);
    ldr_drive(1, 32'h0010_0008, 2'd3, 2'd0, 32'd0);
    @(negedge clk);
    check("t6_post_gnt", {30'd0, core_if.gnt, ldr_if.gnt}, 32'd2);
    tick;
    core_drive(0, 0, 0, 0, 0);
    ldr_drive(0, 0, 0, 0, 0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
